// File: rtl/core_pkg.sv
// Shared pipeline-control types: forwarding select codes and per-stage
// destination-register metadata used by the hazard/forwarding unit.
package core_pkg;

  localparam int CORE_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                       valid;
    logic [CORE_REG_ADDR_W-1:0] rd;
    logic                       reg_write;
    logic                       mem_read;
  } stage_meta_t;

  // x0 is hard-wired to zero, so a stage writing it never produces a value.
  function automatic logic writer_matches(input stage_meta_t m,
                                          input logic [CORE_REG_ADDR_W-1:0] r);
    return m.valid & m.reg_write & (m.rd != '0) & (m.rd == r);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority compare of one ID source register against the EX and MEM writers,
// giving the operand select to register alongside the ID/EX register.
module fwd_sel_calc
  import core_pkg::*;
(
  input  logic [CORE_REG_ADDR_W-1:0] src,
  input  logic                       used,
  input  stage_meta_t                ex_meta,
  input  stage_meta_t                mem_meta,
  output logic [1:0]                 sel
);

  // EX producer is the nearer one; it lands in MEM next cycle, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (used) begin
      if (writer_matches(ex_meta, src)) begin
        sel = FWD_EXMEM;
      end else if (writer_matches(mem_meta, src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Load-use stall detection and registered EX operand-forwarding selects for
// the 5-stage RV32I pipeline, driven by a shadow EX/MEM/WB metadata pipeline.
module fwd_hazard_unit
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = CORE_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [CNT_W-1:0]      stall_count
);

  stage_meta_t ex_q;
  stage_meta_t mem_q;
  stage_meta_t wb_q;
  stage_meta_t id_meta;
  logic [1:0]  next_sel_a;
  logic [1:0]  next_sel_b;
  logic        load_use;

  always_comb begin
    id_meta           = '0;
    id_meta.valid     = id_valid;
    id_meta.rd        = id_rd;
    id_meta.reg_write = id_reg_write;
    id_meta.mem_read  = id_mem_read;
  end

  // A load in EX has no data until MEM ends, so a dependent ID op must wait once.
  always_comb begin
    load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               ((id_rs1_used & (ex_q.rd == id_rs1)) |
                (id_rs2_used & (ex_q.rd == id_rs2)));
    stall    = load_use & ~flush;
  end

  fwd_sel_calc u_sel_a (
    .src      (id_rs1),
    .used     (id_rs1_used),
    .ex_meta  (ex_q),
    .mem_meta (mem_q),
    .sel      (next_sel_a)
  );

  fwd_sel_calc u_sel_b (
    .src      (id_rs2),
    .used     (id_rs2_used),
    .ex_meta  (ex_q),
    .mem_meta (mem_q),
    .sel      (next_sel_b)
  );

  // Bubbles (flush or stall) enter EX with no valid producer and RF selects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_sel_a   <= FWD_RF;
      fwd_sel_b   <= FWD_RF;
      stall_count <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (flush || stall) begin
        ex_q      <= '0;
        fwd_sel_a <= FWD_RF;
        fwd_sel_b <= FWD_RF;
      end else begin
        ex_q      <= id_meta;
        fwd_sel_a <= next_sel_a;
        fwd_sel_b <= next_sel_b;
      end
      if (stall) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed instruction table,
// mid-stream reset, and randomized traffic against a program-order model.
module tb_fwd_hazard_unit;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct {
    instr_t     ins;
    logic       fl;
    logic       estall;
    logic [1:0] esa;
    logic [1:0] esb;
    string      name;
  } vec_t;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ent_t;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_sel_a;
  logic [1:0]  fwd_sel_b;
  logic [31:0] stall_count;

  int          checks;
  int          failures;
  int          exp_count;

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mk(input logic v, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic wr, input logic ld);
    instr_t i;
    i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = 5'(rd); i.wr = wr; i.ld = ld;
    return i;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input instr_t ins, input logic fl);
    id_valid     = ins.v;
    id_rs1       = ins.rs1;
    id_rs2       = ins.rs2;
    id_rs1_used  = ins.u1;
    id_rs2_used  = ins.u2;
    id_rd        = ins.rd;
    id_reg_write = ins.wr;
    id_mem_read  = ins.ld;
    flush        = fl;
  endtask

  // One ID cycle: stall checked mid-cycle, selects/counter just after the edge.
  task automatic applyStimulus(input instr_t ins, input logic fl, input logic estall,
                               input logic [1:0] esa, input logic [1:0] esb,
                               input string tag);
    drive(ins, fl);
    @(negedge clk);
    checkOutput({tag, ".stall"}, {31'd0, stall}, {31'd0, estall});
    if (estall) exp_count++;
    @(posedge clk);
    #1;
    checkOutput({tag, ".sel_a"}, {30'd0, fwd_sel_a}, {30'd0, esa});
    checkOutput({tag, ".sel_b"}, {30'd0, fwd_sel_b}, {30'd0, esb});
    checkOutput({tag, ".count"}, stall_count, exp_count);
  endtask

  // Reference model: the two most recent instructions issued into EX, newest first.
  ent_t hist[$];

  function automatic logic produces(input ent_t e, input logic [4:0] r);
    return e.v && e.wr && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  function automatic logic [1:0] model_sel(input logic u, input logic [4:0] r);
    if (!u) return 2'b00;
    if (produces(hist[0], r)) return 2'b01;
    if (produces(hist[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    ent_t b;
    b = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    exp_count = 0;
  endtask

  vec_t   vecs[$];
  instr_t cur;
  instr_t nop;

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = 0;
    nop       = mk(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    //                 ins                                       fl  stall sa     sb
    vecs.push_back('{mk(1,1,2,1,1,5,1,0),   0, 0, 2'b00, 2'b00, "add_x5"});
    vecs.push_back('{mk(1,5,3,1,1,6,1,0),   0, 0, 2'b01, 2'b00, "add_x6_dep"});
    vecs.push_back('{mk(1,1,2,1,1,5,1,0),   0, 0, 2'b00, 2'b00, "add_x5_b"});
    vecs.push_back('{nop,                   0, 0, 2'b00, 2'b00, "nop"});
    vecs.push_back('{mk(1,0,5,1,1,7,1,0),   0, 0, 2'b00, 2'b10, "sub_x7"});
    vecs.push_back('{mk(1,1,0,1,0,8,1,1),   0, 0, 2'b00, 2'b00, "lw_x8"});
    vecs.push_back('{mk(1,8,8,1,1,9,1,0),   0, 1, 2'b00, 2'b00, "add_x9_stall"});
    vecs.push_back('{mk(1,8,8,1,1,9,1,0),   0, 0, 2'b10, 2'b10, "add_x9_go"});
    vecs.push_back('{mk(1,1,2,1,1,5,1,0),   0, 0, 2'b00, 2'b00, "w1_x5"});
    vecs.push_back('{mk(1,3,4,1,1,5,1,0),   0, 0, 2'b00, 2'b00, "w2_x5"});
    vecs.push_back('{mk(1,5,0,1,1,10,1,0),  0, 0, 2'b01, 2'b00, "rd_x5_near"});
    vecs.push_back('{mk(1,1,2,1,1,0,1,0),   0, 0, 2'b00, 2'b00, "add_x0"});
    vecs.push_back('{mk(1,0,0,1,1,11,1,0),  0, 0, 2'b00, 2'b00, "rd_x0"});
    vecs.push_back('{mk(1,1,0,1,0,0,1,1),   0, 0, 2'b00, 2'b00, "lw_x0"});
    vecs.push_back('{mk(1,0,0,1,1,12,1,0),  0, 0, 2'b00, 2'b00, "rd_x0_ld"});
    vecs.push_back('{mk(1,1,0,1,0,8,1,1),   0, 0, 2'b00, 2'b00, "lw_x8_b"});
    vecs.push_back('{mk(1,8,8,1,1,9,1,0),   1, 0, 2'b00, 2'b00, "add_x9_flush"});
    vecs.push_back('{mk(1,9,8,1,1,13,1,0),  0, 0, 2'b00, 2'b10, "after_flush"});
    vecs.push_back('{mk(1,9,0,1,0,14,1,0),  0, 0, 2'b00, 2'b00, "no_x9_ref"});

    drive(nop, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset.stall", {31'd0, stall}, 32'd0);
    checkOutput("reset.sel_a", {30'd0, fwd_sel_a}, 32'd0);
    checkOutput("reset.sel_b", {30'd0, fwd_sel_b}, 32'd0);
    checkOutput("reset.count", stall_count, 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ins, vecs[i].fl, vecs[i].estall,
                    vecs[i].esa, vecs[i].esb, vecs[i].name);
    end

    // Mid-stream asynchronous reset while a load-use stall is pending.
    applyStimulus(mk(1,1,2,1,1,20,1,0), 0, 0, 2'b00, 2'b00, "add_x20");
    applyStimulus(mk(1,20,0,1,0,8,1,1), 0, 0, 2'b01, 2'b00, "lw_x8_x20");
    drive(mk(1,8,8,1,1,9,1,0), 1'b0);
    #1;
    checkOutput("pre_rst.stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst.stall", {31'd0, stall}, 32'd0);
    checkOutput("async_rst.sel_a", {30'd0, fwd_sel_a}, 32'd0);
    checkOutput("async_rst.sel_b", {30'd0, fwd_sel_b}, 32'd0);
    checkOutput("async_rst.count", stall_count, 32'd0);
    exp_count = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(mk(1,8,8,1,1,9,1,0), 0, 0, 2'b00, 2'b00, "post_rst");

    // Randomized traffic over a small register set to provoke collisions.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    model_reset();
    begin
      logic       held;
      logic       fl;
      logic       es;
      logic [1:0] sa;
      logic [1:0] sb;
      ent_t       e;
      held = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if (!held) begin
          cur = mk($urandom_range(0, 9) != 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                   int'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end
        fl = ($urandom_range(0, 9) == 0);
        es = !fl && cur.v && hist[0].v && hist[0].ld && (hist[0].rd != 5'd0) &&
             ((cur.u1 && hist[0].rd == cur.rs1) || (cur.u2 && hist[0].rd == cur.rs2));
        if (fl || es) begin
          sa = 2'b00;
          sb = 2'b00;
          e  = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
        end else begin
          sa = model_sel(cur.u1, cur.rs1);
          sb = model_sel(cur.u2, cur.rs2);
          e  = '{v: cur.v, rd: cur.rd, wr: cur.wr, ld: cur.ld};
        end
        applyStimulus(cur, fl, es, sa, sb, "rand");
        hist.push_front(e);
        void'(hist.pop_back());
        held = es;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
